// File: rtl/mouse_click_filter.sv
// ---------------------------------------------------------------------------
// mouse_click_filter
//
// Turns the raw MouseCtl left-button level into clean single-cycle click
// events for the game UI. Each event carries the pointer position latched
// at press time. Exactly one pulse is produced per physical press. After
// every release, the button must stay up for a hold-off period before the
// filter re-arms, which hides PS/2 bounce. Coming out of reset, the filter
// does not arm until it has seen a release, so it never emits a phantom
// click.
//
// Ports
//   clk             : system / pixel clock
//   rst             : synchronous reset, active-high
//   enable          : 1 = a press may generate a click event
//   mouse_left      : raw left-button level from MouseCtl
//   mouse_xpos      : pointer x from MouseCtl (12 bit)
//   mouse_ypos      : pointer y from MouseCtl (12 bit)
//   click_pulse     : one-cycle strobe per accepted press
//   click_xpos      : x latched at press, clamped to MAX_X
//   click_ypos      : y latched at press, clamped to MAX_Y
//   click_in_screen : latched raw position was on screen
//   held            : button still down after a recognised press
//   busy            : filter is not idle/armed
// ---------------------------------------------------------------------------
module mouse_click_filter #(
    parameter int HOLDOFF_CYCLES = 650000,
    parameter int CNT_WIDTH      = 20,
    parameter int MAX_X          = 1023,
    parameter int MAX_Y          = 767
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic        click_pulse,
    output logic [11:0] click_xpos,
    output logic [11:0] click_ypos,
    output logic        click_in_screen,
    output logic        held,
    output logic        busy
);

    typedef enum logic [1:0] {
        WAIT_RELEASE,
        HOLDOFF,
        IDLE,
        PRESSED
    } state_t;

    localparam logic [11:0]          MAX_X_C  = 12'(MAX_X);
    localparam logic [11:0]          MAX_Y_C  = 12'(MAX_Y);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(HOLDOFF_CYCLES - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 left_q;
    logic [11:0]          x_q;
    logic [11:0]          y_q;
    logic [11:0]          x_clamped;
    logic [11:0]          y_clamped;
    logic                 on_screen;

    // Button level and pointer position are registered together. The
    // captured coordinates therefore belong to the same sample that shows
    // the press.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            left_q <= mouse_left;
            x_q    <= mouse_xpos;
            y_q    <= mouse_ypos;
        end
    end

    // Each axis is clamped on its own. On-screen status is judged from the
    // raw, unclamped values.
    always_comb begin
        x_clamped = (x_q > MAX_X_C) ? MAX_X_C : x_q;
        y_clamped = (y_q > MAX_Y_C) ? MAX_Y_C : y_q;
        on_screen = (x_q <= MAX_X_C) && (y_q <= MAX_Y_C);
    end

    // Press/release state machine. held and busy are updated on the same
    // edge as each transition, so they always describe the state just
    // entered. A press seen while disabled still moves the machine to
    // PRESSED, so raising enable during that hold cannot fire a late click.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= WAIT_RELEASE;
            cnt             <= '0;
            click_pulse     <= 1'b0;
            click_xpos      <= '0;
            click_ypos      <= '0;
            click_in_screen <= 1'b0;
            held            <= 1'b0;
            busy            <= 1'b1;
        end else begin
            click_pulse <= 1'b0;
            case (state)
                WAIT_RELEASE: begin
                    if (!left_q) begin
                        state <= HOLDOFF;
                        cnt   <= '0;
                    end
                end
                HOLDOFF: begin
                    // Any press during the hold-off window is treated as bounce.
                    if (left_q) begin
                        state <= WAIT_RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                IDLE: begin
                    if (left_q) begin
                        state <= PRESSED;
                        held  <= 1'b1;
                        busy  <= 1'b1;
                        if (enable) begin
                            click_pulse     <= 1'b1;
                            click_xpos      <= x_clamped;
                            click_ypos      <= y_clamped;
                            click_in_screen <= on_screen;
                        end
                    end
                end
                PRESSED: begin
                    if (!left_q) begin
                        state <= HOLDOFF;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end
                end
                default: begin
                    state <= WAIT_RELEASE;
                    held  <= 1'b0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_click_filter.sv
// ---------------------------------------------------------------------------
// tb_mouse_click_filter
//
// Drives mouse_click_filter with a short hold-off (4 cycles). The stimulus
// is a sequence of directed scenarios followed by a randomized run. A
// behavioural model is stepped once per clock edge. It reasons only about
// how long the sampled button has been continuously released, and it checks
// every output after every edge.
// ---------------------------------------------------------------------------
module tb_mouse_click_filter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mouse_left;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        click_pulse;
    logic [11:0] click_xpos;
    logic [11:0] click_ypos;
    logic        click_in_screen;
    logic        held;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    // Reference model state: last sampled inputs and the length of the
    // current run of released samples.
    bit          m_left;
    logic [11:0] m_x;
    logic [11:0] m_y;
    int          low_run;
    bit          m_pressed;
    bit          e_pulse;
    logic [11:0] e_x;
    logic [11:0] e_y;
    bit          e_in;
    bit          e_held;
    bit          e_busy;

    mouse_click_filter #(
        .HOLDOFF_CYCLES(HOLD),
        .CNT_WIDTH     (20),
        .MAX_X         (1023),
        .MAX_Y         (767)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .mouse_left     (mouse_left),
        .mouse_xpos     (mouse_xpos),
        .mouse_ypos     (mouse_ypos),
        .click_pulse    (click_pulse),
        .click_xpos     (click_xpos),
        .click_ypos     (click_ypos),
        .click_in_screen(click_in_screen),
        .held           (held),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // A click is accepted when the sampled button is down, it has been up
    // for more than the hold-off length, and enable is high.
    task automatic modelEdge(input bit r, input bit en, input bit l,
                             input logic [11:0] x, input logic [11:0] y);
        bit armed;
        if (r) begin
            m_left = 0; m_x = 0; m_y = 0; low_run = 0; m_pressed = 0;
            e_pulse = 0; e_x = 0; e_y = 0; e_in = 0; e_held = 0; e_busy = 1;
        end else begin
            armed   = (low_run >= HOLD + 1);
            e_pulse = m_left && armed && en;
            if (e_pulse) begin
                e_x  = (m_x > 12'd1023) ? 12'd1023 : m_x;
                e_y  = (m_y > 12'd767) ? 12'd767 : m_y;
                e_in = (m_x <= 12'd1023) && (m_y <= 12'd767);
            end
            m_pressed = m_left && (m_pressed || armed);
            if (m_left) low_run = 0;
            else if (low_run < 1000) low_run = low_run + 1;
            e_held = m_pressed;
            e_busy = !(!m_left && low_run >= HOLD + 1);
            m_left = l; m_x = x; m_y = y;
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        vectors++;
        checkValue("click_pulse", int'(click_pulse), int'(e_pulse));
        checkValue("click_xpos", int'(click_xpos), int'(e_x));
        checkValue("click_ypos", int'(click_ypos), int'(e_y));
        checkValue("click_in_screen", int'(click_in_screen), int'(e_in));
        checkValue("held", int'(held), int'(e_held));
        checkValue("busy", int'(busy), int'(e_busy));
    endtask

    // One clock cycle: drive the inputs, step the model at the edge, then
    // compare just after the edge.
    task automatic applyStimulus(input bit r, input bit en, input bit l,
                                 input logic [11:0] x, input logic [11:0] y);
        rst = r; enable = en; mouse_left = l; mouse_xpos = x; mouse_ypos = y;
        @(posedge clk);
        modelEdge(r, en, l, x, y);
        #1;
        if (click_pulse === 1'b1) pulses++;
        checkOutput();
    endtask

    task automatic repeatStim(input int n, input bit r, input bit en, input bit l,
                              input logic [11:0] x, input logic [11:0] y);
        for (int i = 0; i < n; i++) applyStimulus(r, en, l, x, y);
    endtask

    initial begin
        bit          r_l;
        bit          r_en;
        bit          r_rst;
        logic [11:0] r_x;
        logic [11:0] r_y;

        $display("[TB] reset");
        repeat (2) applyStimulus(1, 1, 0, 12'd0, 12'd0);
        checkValue("reset_busy", int'(busy), 1);
        checkValue("reset_held", int'(held), 0);

        $display("[TB] basic press");
        repeat (6) applyStimulus(0, 1, 0, 12'd0, 12'd0);
        checkValue("idle_busy", int'(busy), 0);
        pulses = 0;
        applyStimulus(0, 1, 1, 12'd100, 12'd200);
        checkValue("latency_1", int'(click_pulse), 0);
        applyStimulus(0, 1, 1, 12'd100, 12'd200);
        checkValue("latency_2", int'(click_pulse), 1);
        repeatStim(3, 0, 1, 1, 12'd300, 12'd300);
        checkValue("t1_pulses", pulses, 1);
        checkValue("t1_x", int'(click_xpos), 100);
        checkValue("t1_y", int'(click_ypos), 200);
        checkValue("t1_in", int'(click_in_screen), 1);
        checkValue("t1_held", int'(held), 1);
        repeatStim(6, 0, 1, 0, 12'd0, 12'd0);

        $display("[TB] held through reset");
        pulses = 0;
        repeatStim(2, 1, 1, 1, 12'd10, 12'd10);
        repeatStim(20, 0, 1, 1, 12'd10, 12'd10);
        checkValue("t2_no_pulse", pulses, 0);
        repeatStim(5, 0, 1, 0, 12'd10, 12'd10);
        repeatStim(4, 0, 1, 1, 12'd20, 12'd30);
        checkValue("t2_pulses", pulses, 1);
        repeatStim(6, 0, 1, 0, 12'd0, 12'd0);

        $display("[TB] bounce");
        pulses = 0;
        repeatStim(4, 0, 1, 1, 12'd40, 12'd40);
        repeatStim(2, 0, 1, 0, 12'd40, 12'd40);
        repeatStim(4, 0, 1, 1, 12'd41, 12'd41);
        checkValue("t3_one_pulse", pulses, 1);
        checkValue("t3_busy", int'(busy), 1);
        checkValue("t3_held", int'(held), 0);
        repeatStim(6, 0, 1, 0, 12'd0, 12'd0);
        repeatStim(3, 0, 1, 1, 12'd42, 12'd43);
        checkValue("t3_rearm", pulses, 2);
        repeatStim(6, 0, 1, 0, 12'd0, 12'd0);

        $display("[TB] enable gating");
        pulses = 0;
        repeatStim(3, 0, 0, 1, 12'd50, 12'd50);
        repeatStim(3, 0, 1, 1, 12'd50, 12'd50);
        checkValue("t4_no_pulse", pulses, 0);
        repeatStim(5, 0, 1, 0, 12'd0, 12'd0);
        repeatStim(3, 0, 1, 1, 12'd60, 12'd70);
        checkValue("t4_pulses", pulses, 1);
        repeatStim(6, 0, 1, 0, 12'd0, 12'd0);

        $display("[TB] clamp");
        repeatStim(3, 0, 1, 1, 12'd1500, 12'd900);
        checkValue("t5_x", int'(click_xpos), 1023);
        checkValue("t5_y", int'(click_ypos), 767);
        checkValue("t5_in", int'(click_in_screen), 0);
        repeatStim(6, 0, 1, 0, 12'd0, 12'd0);
        repeatStim(3, 0, 1, 1, 12'd5, 12'd5);
        checkValue("t5_in2", int'(click_in_screen), 1);
        repeatStim(6, 0, 1, 0, 12'd0, 12'd0);

        $display("[TB] reset while pressed");
        pulses = 0;
        repeatStim(3, 0, 1, 1, 12'd80, 12'd80);
        applyStimulus(1, 1, 1, 12'd80, 12'd80);
        checkValue("t6_busy", int'(busy), 1);
        checkValue("t6_x", int'(click_xpos), 0);
        checkValue("t6_held", int'(held), 0);
        repeatStim(5, 0, 1, 1, 12'd80, 12'd80);
        checkValue("t6_no_pulse", pulses, 1);
        repeatStim(6, 0, 1, 0, 12'd0, 12'd0);
        repeatStim(3, 0, 1, 1, 12'd90, 12'd91);
        checkValue("t6_pulses", pulses, 2);

        $display("[TB] random run");
        r_l = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) r_l = !r_l;
            r_en  = ($urandom_range(3) != 0);
            r_rst = ($urandom_range(199) == 0);
            r_x   = 12'($urandom_range(4095));
            r_y   = 12'($urandom_range(4095));
            applyStimulus(r_rst, r_en, r_l, r_x, r_y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
